wshbn_arbiter_2m: RTL and testbench
===================================

WSHBN_ARBITER_2M -- requirements
Module: wshbn_arbiter_2m

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default ADDR_WIDTH from cache_parameters, address width of all ADR ports.
REQ-002 SHALL have parameter WORD_WIDTH, default WORD_WIDTH from cache_parameters, data width of all DAT ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, number of un-acked strobe cycles before error.
REQ-004 SHALL have port CLK_I  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RST_I  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports M0_ADR_I/M1_ADR_I  input  ADDR_WIDTH  master address.
REQ-007 SHALL have ports M0_DAT_I/M1_DAT_I  input  WORD_WIDTH  master write data.
REQ-008 SHALL have ports M0_WE_I, M0_STB_I, M0_CYC_I, M1_WE_I, M1_STB_I, M1_CYC_I  input  1 each  master Wishbone controls.
REQ-009 SHALL have ports M0_DAT_O/M1_DAT_O  output  WORD_WIDTH  read data to master.
REQ-010 SHALL have ports M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O  output  1 each  termination to master.
REQ-011 SHALL have ports S_ADR_O  output  ADDR_WIDTH; S_DAT_O  output  WORD_WIDTH; S_WE_O, S_STB_O, S_CYC_O  output  1 each  shared slave (RAM) side.
REQ-012 SHALL have ports S_DAT_I  input  WORD_WIDTH; S_ACK_I  input  1  slave response.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, GNT0, GNT1, GAP.
REQ-014 IDLE: request x = Mx_CYC_I & Mx_STB_I; SHALL enter GNTx on next edge; single request wins; both requesting: master not equal to last_grant wins.
REQ-015 last_grant SHALL be a 1-bit flop updated to x on every IDLE->GNTx transition; reset value 1 (M0 wins first tie).
REQ-016 GNTx: SHALL pass Mx ADR/DAT/WE/STB/CYC combinationally to S_* outputs; S_DAT_I to Mx_DAT_O; S_ACK_I to Mx_ACK_O.
REQ-017 GNTx: non-granted master's ACK_O/ERR_O SHALL be 0 and its DAT_O SHALL be 0; its requests are held off (no slave visibility).
REQ-018 GNTx: SHALL stay while Mx_CYC_I=1 (multi-beat bursts keep ownership); Mx_CYC_I=0 -> GAP on next edge.
REQ-019 GAP: SHALL drive S_CYC_O=S_STB_O=0 for exactly one cycle, then IDLE; guarantees slave returns to its idle state between owners.
REQ-020 IDLE and GAP: S_ADR_O, S_DAT_O, S_WE_O, S_STB_O, S_CYC_O SHALL be 0; all master ACK/ERR/DAT outputs 0.
REQ-021 Arbitration latency: request in IDLE at edge N -> slave sees STB at cycle N+1; end-to-end ACK latency = 1 + slave latency (slave RAM: 3 cycles -> ACK 4 cycles after request).
REQ-022 Timeout counter: width ceil(log2(TIMEOUT_CYCLES+1)); in GNTx increments each cycle with Mx_STB_I=1 and S_ACK_I=0; clears on S_ACK_I=1, on Mx_STB_I=0, and on leaving GNTx.
REQ-023 When counter reaches TIMEOUT_CYCLES-1 with no ACK in that cycle, SHALL assert Mx_ERR_O for exactly that one cycle, clear counter, keep grant; master is expected to drop CYC.
REQ-024 ACK and ERR to the same master SHALL never be asserted together; ACK has priority (timeout suppressed on an ACK cycle).
REQ-025 Master dropping CYC mid-transfer (before ACK) SHALL still go GAP->IDLE; any late S_ACK_I during GAP/IDLE SHALL be discarded.
REQ-026 Simultaneous release by owner and new request by other master: release cycle -> GAP, other master granted via IDLE two edges later.

Reset
REQ-027 RST_I=1 SHALL force state=IDLE, last_grant=1, counter=0 immediately (asynchronous), all outputs 0 per REQ-020, regardless of transfer in progress.
REQ-028 Release of RST_I SHALL take effect on the next rising CLK_I; first arbitration decision on that edge.

Verification
REQ-029 M0 read alone, ADR=0x10, slave returns 0xDEADBEEF with 3-cycle latency -> M0_ACK_O one cycle with M0_DAT_O=0xDEADBEEF, 4 cycles after request; M1 outputs stay 0.
REQ-030 Both masters request same cycle after reset -> M0 granted; after M0 releases, GAP 1 cycle, M1 granted; next tie -> M0 (round-robin).
REQ-031 M1 write ADR=0x20 DAT=0x12345678 during M0 burst of 3 beats -> S_ADR_O never shows 0x20 until M0 CYC drops; one GAP cycle with S_CYC_O=0 precedes M1.
REQ-032 Slave ACK tied 0, M0 STB held -> M0_ERR_O single pulse at cycle 16 of GNT0; no M0_ACK_O; grant retained until CYC drops.
REQ-033 RST_I asserted mid-GNT1 (between STB and ACK) -> all outputs 0 asynchronously; after release, tie resolves to M0.
REQ-034 M0 drops CYC before ACK, slave ACKs during GAP -> no ACK forwarded to either master.

Source files
------------

// File: rtl/wshbn_arbiter_2m.sv
// Two-master Wishbone arbiter in front of one shared slave (RAM).
// Round-robin on ties, whole-cycle ownership, one GAP cycle between owners, per-strobe timeout.
module wshbn_arbiter_2m #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [ADDR_WIDTH-1:0] M0_ADR_I,
    input  logic [WORD_WIDTH-1:0] M0_DAT_I,
    input  logic                  M0_WE_I,
    input  logic                  M0_STB_I,
    input  logic                  M0_CYC_I,
    output logic [WORD_WIDTH-1:0] M0_DAT_O,
    output logic                  M0_ACK_O,
    output logic                  M0_ERR_O,
    input  logic [ADDR_WIDTH-1:0] M1_ADR_I,
    input  logic [WORD_WIDTH-1:0] M1_DAT_I,
    input  logic                  M1_WE_I,
    input  logic                  M1_STB_I,
    input  logic                  M1_CYC_I,
    output logic [WORD_WIDTH-1:0] M1_DAT_O,
    output logic                  M1_ACK_O,
    output logic                  M1_ERR_O,
    output logic [ADDR_WIDTH-1:0] S_ADR_O,
    output logic [WORD_WIDTH-1:0] S_DAT_O,
    output logic                  S_WE_O,
    output logic                  S_STB_O,
    output logic                  S_CYC_O,
    input  logic [WORD_WIDTH-1:0] S_DAT_I,
    input  logic                  S_ACK_I
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1,
        GAP
    } state_t;

    state_t               state, state_next;
    logic                 last_grant, last_grant_next;
    logic [CNT_WIDTH-1:0] tmo_cnt, tmo_cnt_next;
    logic                 req0, req1;
    logic                 own_stb;
    logic                 tmo_hit;

    assign req0 = M0_CYC_I & M0_STB_I;
    assign req1 = M1_CYC_I & M1_STB_I;

    assign own_stb = (state == GNT0) ? M0_STB_I :
                     (state == GNT1) ? M1_STB_I : 1'b0;

    // An ACK in the same cycle wins over the timeout.
    assign tmo_hit = own_stb & ~S_ACK_I &
                     (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            tmo_cnt    <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        tmo_cnt_next    = '0;
        S_ADR_O         = '0;
        S_DAT_O         = '0;
        S_WE_O          = 1'b0;
        S_STB_O         = 1'b0;
        S_CYC_O         = 1'b0;
        M0_DAT_O        = '0;
        M0_ACK_O        = 1'b0;
        M0_ERR_O        = 1'b0;
        M1_DAT_O        = '0;
        M1_ACK_O        = 1'b0;
        M1_ERR_O        = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the master that did not own the bus last time wins.
                if (req0 && (!req1 || last_grant)) begin
                    state_next      = GNT0;
                    last_grant_next = 1'b0;
                end else if (req1) begin
                    state_next      = GNT1;
                    last_grant_next = 1'b1;
                end
            end
            GNT0: begin
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                S_WE_O   = M0_WE_I;
                S_STB_O  = M0_STB_I;
                S_CYC_O  = M0_CYC_I;
                M0_DAT_O = S_DAT_I;
                M0_ACK_O = S_ACK_I;
                M0_ERR_O = tmo_hit;
                if (!M0_CYC_I) begin
                    state_next = GAP;
                end
            end
            GNT1: begin
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                S_WE_O   = M1_WE_I;
                S_STB_O  = M1_STB_I;
                S_CYC_O  = M1_CYC_I;
                M1_DAT_O = S_DAT_I;
                M1_ACK_O = S_ACK_I;
                M1_ERR_O = tmo_hit;
                if (!M1_CYC_I) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (own_stb && !S_ACK_I && !tmo_hit && (state_next == state)) begin
            tmo_cnt_next = tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wshbn_arbiter_2m.sv
// Self-checking bench for wshbn_arbiter_2m with a 3-cycle-latency slave model
// and a scoreboard of expected read data per acknowledged beat.
module tb_wshbn_arbiter_2m;

    localparam int AW  = 32;
    localparam int WW  = 32;
    localparam int TMO = 16;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic [AW-1:0] M0_ADR_I, M1_ADR_I, S_ADR_O;
    logic [WW-1:0] M0_DAT_I, M1_DAT_I, M0_DAT_O, M1_DAT_O, S_DAT_O, S_DAT_I;
    logic          M0_WE_I, M0_STB_I, M0_CYC_I, M1_WE_I, M1_STB_I, M1_CYC_I;
    logic          M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O;
    logic          S_WE_O, S_STB_O, S_CYC_O, S_ACK_I;

    typedef struct packed {
        logic          m;
        logic [WW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic ack_en      = 1'b1;
    logic force_ack   = 1'b0;
    int   lat_cnt     = 0;

    wire [AW+3*WW+6:0] all_outs = {S_ADR_O, S_DAT_O, S_WE_O, S_STB_O, S_CYC_O,
                                   M0_DAT_O, M0_ACK_O, M0_ERR_O,
                                   M1_DAT_O, M1_ACK_O, M1_ERR_O};

    wshbn_arbiter_2m #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(WW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_WE_I(M0_WE_I),
        .M0_STB_I(M0_STB_I), .M0_CYC_I(M0_CYC_I),
        .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
        .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_WE_I(M1_WE_I),
        .M1_STB_I(M1_STB_I), .M1_CYC_I(M1_CYC_I),
        .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
        .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_WE_O(S_WE_O),
        .S_STB_O(S_STB_O), .S_CYC_O(S_CYC_O),
        .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic logic [WW-1:0] slave_data(input logic [AW-1:0] addr);
        if (addr == 32'h10) return 32'hDEADBEEF;
        return (addr * 32'h0101_0101) + 32'h5A5A_0000;
    endfunction

    // Slave model: ACK on the 4th cycle of a continuous strobe, read data valid while strobed.
    always @(posedge CLK_I) begin
        if (!(S_CYC_O && S_STB_O) || S_ACK_I) lat_cnt <= 0;
        else                                  lat_cnt <= lat_cnt + 1;
    end
    assign S_ACK_I = force_ack | (ack_en & S_CYC_O & S_STB_O & (lat_cnt == 3));
    assign S_DAT_I = (S_STB_O && !S_WE_O) ? slave_data(S_ADR_O) : '0;

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            vectors++;
            if ((M0_ACK_O && M0_ERR_O) || (M1_ACK_O && M1_ERR_O)) begin
                miscompares++;
                $display("[TB] FAIL ack_err_exclusive: m0 ack/err=%b%b m1 ack/err=%b%b, required never both",
                         M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic idle_masters;
        M0_ADR_I = '0; M0_DAT_I = '0; M0_WE_I = 1'b0; M0_STB_I = 1'b0; M0_CYC_I = 1'b0;
        M1_ADR_I = '0; M1_DAT_I = '0; M1_WE_I = 1'b0; M1_STB_I = 1'b0; M1_CYC_I = 1'b0;
    endtask

    task automatic req_m0(input logic [AW-1:0] adr);
        M0_ADR_I = adr; M0_WE_I = 1'b0; M0_CYC_I = 1'b1; M0_STB_I = 1'b1;
    endtask

    task automatic req_m1(input logic [AW-1:0] adr);
        M1_ADR_I = adr; M1_WE_I = 1'b0; M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
    endtask

    task automatic do_reset;
        idle_masters();
        ack_en    = 1'b1;
        force_ack = 1'b0;
        RST_I     = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
    endtask

    task automatic wait_ack(input int m, input int budget, output int cycles, output bit found);
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            step();
            cycles++;
            if (((m == 0) ? M0_ACK_O : M1_ACK_O) === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        idle_masters();
        req_m0(32'h10);
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        vectors++;
        if (all_outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", all_outs);
        end
        do_reset();
    endtask

    task automatic test_single_read;
        exp_t e;
        int   k;
        bit   found;
        bit   m1_bad;
        do_reset();
        e.m = 1'b0; e.data = 32'hDEADBEEF;
        sb.push_back(e);
        req_m0(32'h10);
        k = 0; found = 1'b0; m1_bad = 1'b0;
        while (!found && k < 20) begin
            step();
            k++;
            if (k == 1) begin
                vectors++;
                if (S_STB_O !== 1'b1 || S_ADR_O !== 32'h10) begin
                    miscompares++;
                    $display("[TB] FAIL read_first_stb: stb=%b adr=%h, required stb=1 adr=00000010", S_STB_O, S_ADR_O);
                end
            end
            if ({M1_ACK_O, M1_ERR_O, M1_DAT_O} !== '0) m1_bad = 1'b1;
            if (M0_ACK_O === 1'b1) found = 1'b1;
        end
        vectors++;
        if (!found || k != 4) begin
            miscompares++;
            $display("[TB] FAIL read_latency: ack after %0d cycles (found=%0b), required 4", k, found);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (found) begin
                vectors++;
                if (M0_DAT_O !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL read_data: got %h, required %h", M0_DAT_O, e.data);
                end
            end
        end
        vectors++;
        if (m1_bad) begin
            miscompares++;
            $display("[TB] FAIL read_m1_quiet: M1 outputs nonzero, required 0");
        end
        idle_masters();
        step();
        vectors++;
        if (S_CYC_O !== 1'b0 || S_STB_O !== 1'b0 || M0_ACK_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_gap: cyc=%b stb=%b ack=%b, required 0 0 0", S_CYC_O, S_STB_O, M0_ACK_O);
        end
        step();
    endtask

    task automatic test_round_robin;
        exp_t e;
        int   k;
        bit   found;
        do_reset();
        e.m = 1'b0; e.data = slave_data(32'h04); sb.push_back(e);
        e.m = 1'b1; e.data = slave_data(32'h08); sb.push_back(e);
        req_m0(32'h04);
        req_m1(32'h08);
        step();
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h04) begin
            miscompares++;
            $display("[TB] FAIL rr_first_tie: cyc=%b adr=%h, required cyc=1 adr=00000004", S_CYC_O, S_ADR_O);
        end
        wait_ack(0, 10, k, found);
        e = sb.pop_front();
        vectors++;
        if (!found || M0_DAT_O !== e.data) begin
            miscompares++;
            $display("[TB] FAIL rr_m0_data: found=%0b data=%h, required ack with %h", found, M0_DAT_O, e.data);
        end
        M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
        step();
        vectors++;
        if (S_CYC_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_gap: cyc=%b, required 0", S_CYC_O);
        end
        step();
        vectors++;
        if (S_CYC_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_idle: cyc=%b, required 0", S_CYC_O);
        end
        step();
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h08) begin
            miscompares++;
            $display("[TB] FAIL rr_m1_grant: cyc=%b adr=%h, required cyc=1 adr=00000008", S_CYC_O, S_ADR_O);
        end
        wait_ack(1, 10, k, found);
        e = sb.pop_front();
        vectors++;
        if (!found || M1_DAT_O !== e.data) begin
            miscompares++;
            $display("[TB] FAIL rr_m1_data: found=%0b data=%h, required ack with %h", found, M1_DAT_O, e.data);
        end
        M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
        step();
        req_m0(32'h0C);
        req_m1(32'h14);
        step();
        step();
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h0C) begin
            miscompares++;
            $display("[TB] FAIL rr_second_tie: cyc=%b adr=%h, required cyc=1 adr=0000000c", S_CYC_O, S_ADR_O);
        end
        idle_masters();
        step();
        step();
    endtask

    task automatic test_burst_hold;
        exp_t e;
        int   cyc;
        int   beat;
        int   k;
        bit   found;
        bit   bad_adr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e.m = 1'b0; e.data = slave_data(32'h30 + 4 * i); sb.push_back(e);
        end
        e.m = 1'b1; e.data = '0; sb.push_back(e);
        req_m0(32'h30);
        cyc = 0; beat = 0; bad_adr = 1'b0;
        while (beat < 3 && cyc < 60) begin
            step();
            cyc++;
            if (S_ADR_O === 32'h20 || M1_ACK_O !== 1'b0) bad_adr = 1'b1;
            if (cyc == 1) begin
                M1_ADR_I = 32'h20; M1_DAT_I = 32'h12345678; M1_WE_I = 1'b1;
                M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
            end
            if (M0_ACK_O === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (M0_DAT_O !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL burst_beat%0d_data: got %h, required %h", beat, M0_DAT_O, e.data);
                end
                beat++;
                if (beat < 3) M0_ADR_I = 32'h30 + 4 * beat;
                else begin
                    M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
                end
            end
        end
        vectors++;
        if (beat != 3) begin
            miscompares++;
            $display("[TB] FAIL burst_beats: got %0d beats, required 3", beat);
        end
        vectors++;
        if (bad_adr) begin
            miscompares++;
            $display("[TB] FAIL burst_holdoff: M1 visible to slave during M0 burst, required hidden");
        end
        step();
        vectors++;
        if (S_CYC_O !== 1'b0 || S_STB_O !== 1'b0 || S_ADR_O !== '0) begin
            miscompares++;
            $display("[TB] FAIL burst_gap: cyc=%b stb=%b adr=%h, required 0 0 0", S_CYC_O, S_STB_O, S_ADR_O);
        end
        step();
        step();
        vectors++;
        if ({S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O} !== {32'h20, 32'h12345678, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL burst_m1_write: adr=%h dat=%h we=%b cyc=%b, required 00000020 12345678 1 1",
                     S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O);
        end
        wait_ack(1, 10, k, found);
        e = sb.pop_front();
        vectors++;
        if (!found || M1_DAT_O !== e.data) begin
            miscompares++;
            $display("[TB] FAIL burst_m1_ack: found=%0b data=%h, required ack with %h", found, M1_DAT_O, e.data);
        end
        idle_masters();
        step();
        step();
    endtask

    task automatic test_timeout;
        int errs;
        int first_err;
        int acks;
        do_reset();
        ack_en = 1'b0;
        req_m0(32'h40);
        errs = 0; first_err = 0; acks = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (M0_ERR_O === 1'b1) begin
                errs++;
                if (first_err == 0) first_err = k;
            end
            if (M0_ACK_O === 1'b1) acks++;
        end
        vectors++;
        if (errs != 1 || first_err != TMO) begin
            miscompares++;
            $display("[TB] FAIL timeout_err: %0d pulses first at cycle %0d, required 1 pulse at %0d", errs, first_err, TMO);
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_no_ack: %0d acks, required 0", acks);
        end
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL timeout_grant_kept: cyc=%b adr=%h, required 1 00000040", S_CYC_O, S_ADR_O);
        end
        idle_masters();
        ack_en = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_m1(32'h50);
        step();
        step();
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h50 || M1_ACK_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_pre: cyc=%b adr=%h ack=%b, required 1 00000050 0", S_CYC_O, S_ADR_O, M1_ACK_O);
        end
        req_m0(32'h60);
        RST_I = 1'b1;
        #1;
        vectors++;
        if (all_outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_async: got %h, required 0", all_outs);
        end
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        step();
        vectors++;
        if (S_CYC_O !== 1'b1 || S_ADR_O !== 32'h60) begin
            miscompares++;
            $display("[TB] FAIL rstmid_tie: cyc=%b adr=%h, required 1 00000060", S_CYC_O, S_ADR_O);
        end
        idle_masters();
        step();
        step();
    endtask

    task automatic test_late_ack;
        do_reset();
        req_m0(32'h70);
        step();
        step();
        idle_masters();
        step();
        force_ack = 1'b1;
        #1;
        vectors++;
        if (M0_ACK_O !== 1'b0 || M1_ACK_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_ack_gap: m0=%b m1=%b, required 0 0", M0_ACK_O, M1_ACK_O);
        end
        step();
        vectors++;
        if (M0_ACK_O !== 1'b0 || M1_ACK_O !== 1'b0 || S_CYC_O !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_ack_idle: m0=%b m1=%b cyc=%b, required 0 0 0", M0_ACK_O, M1_ACK_O, S_CYC_O);
        end
        force_ack = 1'b0;
        step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        idle_masters();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_hold();
        test_timeout();
        test_reset_mid();
        test_late_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
